// File: rtl/ysyx_25020047_ctrl.sv
// Multi-cycle core sequencer: fetch/decode/exec/mem/writeback with request
// timeouts, sticky halt/error states and cycle/retire counters.
module ysyx_25020047_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_type,
  input  logic        if_ready,
  input  logic        mem_ready,
  output logic        if_req,
  output logic        inst_wen,
  output logic        mem_req,
  output logic        mem_wen,
  output logic        reg_wen,
  output logic        pc_wen,
  output logic        halt,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [2:0]  state,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
);

  // state  | meaning
  // FETCH  | request instruction, wait for if_ready
  // DECODE | capture class, branch
  // EXEC   | single-cycle ALU slot
  // MEM    | data request, wait for mem_ready
  // WB     | register + PC writeback, retire
  // HALT   | ebreak reached, absorbing
  // ERR    | illegal inst or timeout, absorbing
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5,
    ERR    = 3'd6
  } state_e;

  localparam logic [31:0] CL_ADDI   = 32'h1;
  localparam logic [31:0] CL_JALR   = 32'h2;
  localparam logic [31:0] CL_EBREAK = 32'h4;
  localparam logic [31:0] CL_ADD    = 32'h8;
  localparam logic [31:0] CL_LUI    = 32'h10;
  localparam logic [31:0] CL_LW     = 32'h20;
  localparam logic [31:0] CL_LBU    = 32'h40;
  localparam logic [31:0] CL_SW     = 32'h80;
  localparam logic [31:0] CL_SB     = 32'h160;
  localparam logic [31:0] CL_AUIPC  = 32'h320;
  localparam logic [31:0] CL_JAL    = 32'h640;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q;
  logic [31:0] class_q;
  logic [7:0]  wait_q;
  logic [1:0]  err_code_q;
  logic [31:0] cycle_q;
  logic [31:0] instret_q;

  logic is_store;
  logic is_mem_inst;
  logic is_alu_inst;

  assign is_store    = (class_q == CL_SW) || (class_q == CL_SB);
  assign is_mem_inst = (inst_type == CL_LW) || (inst_type == CL_LBU) ||
                       (inst_type == CL_SW) || (inst_type == CL_SB);
  assign is_alu_inst = (inst_type == CL_ADDI) || (inst_type == CL_JALR) ||
                       (inst_type == CL_ADD) || (inst_type == CL_LUI) ||
                       (inst_type == CL_AUIPC) || (inst_type == CL_JAL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= FETCH;
      class_q    <= '0;
      wait_q     <= '0;
      err_code_q <= '0;
      cycle_q    <= '0;
      instret_q  <= '0;
    end else begin
      if (state_q != HALT && state_q != ERR) cycle_q <= cycle_q + 32'd1;
      case (state_q)
        FETCH: begin
          if (if_ready) begin
            state_q <= DECODE;
          end else if (wait_q == WAIT_LAST) begin
            state_q    <= ERR;
            err_code_q <= 2'd2;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        DECODE: begin
          class_q <= inst_type;
          if (inst_type == CL_EBREAK) begin
            state_q   <= HALT;
            instret_q <= instret_q + 32'd1;
          end else if (is_mem_inst) begin
            state_q <= MEM;
            wait_q  <= '0;
          end else if (is_alu_inst) begin
            state_q <= EXEC;
          end else begin
            state_q    <= ERR;
            err_code_q <= 2'd1;
          end
        end
        EXEC: state_q <= WB;
        MEM: begin
          if (mem_ready) begin
            if (is_store) begin
              state_q   <= FETCH;
              wait_q    <= '0;
              instret_q <= instret_q + 32'd1;
            end else begin
              state_q <= WB;
            end
          end else if (wait_q == WAIT_LAST) begin
            state_q    <= ERR;
            err_code_q <= 2'd3;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        WB: begin
          state_q   <= FETCH;
          wait_q    <= '0;
          instret_q <= instret_q + 32'd1;
        end
        default: state_q <= state_q;
      endcase
    end
  end

  // Strobes depend only on state, captured class and ready inputs.
  always_comb begin
    if_req   = 1'b0;
    inst_wen = 1'b0;
    mem_req  = 1'b0;
    mem_wen  = 1'b0;
    reg_wen  = 1'b0;
    pc_wen   = 1'b0;
    case (state_q)
      FETCH: begin
        if_req   = 1'b1;
        inst_wen = if_ready;
      end
      MEM: begin
        mem_req = 1'b1;
        mem_wen = is_store;
        pc_wen  = mem_ready && is_store;
      end
      WB: begin
        reg_wen = 1'b1;
        pc_wen  = 1'b1;
      end
      default: ;
    endcase
  end

  assign halt        = (state_q == HALT);
  assign err         = (state_q == ERR);
  assign err_code    = err_code_q;
  assign state       = state_q;
  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;

endmodule

// File: doc/ysyx_25020047_ctrl.md
YSYX_25020047_CTRL -- requirements
Module: ysyx_25020047_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning max consecutive request cycles without ready before error (range 2..255).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port inst_type  input  32  IDU class code: 0x1 addi, 0x2 jalr, 0x4 ebreak, 0x8 add, 0x10 lui, 0x20 lw, 0x40 lbu, 0x80 sw, 0x160 sb, 0x320 auipc, 0x640 jal; any other value is illegal.
REQ-005 SHALL have port if_ready  input  1  instruction memory response valid.
REQ-006 SHALL have port mem_ready  input  1  data memory response valid.
REQ-007 SHALL have port if_req  output  1  instruction fetch request.
REQ-008 SHALL have port inst_wen  output  1  latch-instruction strobe.
REQ-009 SHALL have port mem_req  output  1  data memory request.
REQ-010 SHALL have port mem_wen  output  1  data memory write (store).
REQ-011 SHALL have port reg_wen  output  1  GPR write enable.
REQ-012 SHALL have port pc_wen  output  1  PC update enable (load dnpc).
REQ-013 SHALL have port halt  output  1  ebreak reached.
REQ-014 SHALL have port err  output  1  sticky error.
REQ-015 SHALL have port err_code  output  2  0 none, 1 illegal inst, 2 fetch timeout, 3 mem timeout.
REQ-016 SHALL have port state  output  3  current FSM state, debug.
REQ-017 SHALL have port cycle_cnt  output  32  active cycle counter.
REQ-018 SHALL have port instret_cnt  output  32  retired instruction counter.

Function
REQ-019 SHALL implement FSM states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, ERR=6.
REQ-020 SHALL, in FETCH, assert if_req=1; inst_wen=if_ready (same cycle); on if_ready go to DECODE.
REQ-021 SHALL, in DECODE (1 cycle), register inst_type into an internal class register and branch: 0x4 -> HALT; lw/lbu/sw/sb -> MEM; other legal codes -> EXEC; illegal -> ERR with err_code=1.
REQ-022 SHALL, in EXEC (1 cycle), go to WB with all outputs 0.
REQ-023 SHALL, in MEM, assert mem_req=1 and mem_wen=1 for sw/sb else 0; hold both until mem_ready.
REQ-024 SHALL, on mem_ready in MEM: loads -> WB; stores -> FETCH with pc_wen=1 and instret_cnt+1 that same cycle.
REQ-025 SHALL, in WB (1 cycle), assert reg_wen=1 and pc_wen=1, increment instret_cnt, go to FETCH.
REQ-026 SHALL never assert reg_wen for sw, sb, ebreak or illegal codes.
REQ-027 SHALL count ebreak as retired: instret_cnt+1 on DECODE->HALT; pc_wen stays 0.
REQ-028 SHALL keep a wait counter cleared on entry to FETCH/MEM, incremented each request cycle without ready.
REQ-029 SHALL go to ERR after TIMEOUT consecutive unanswered request cycles (err_code 2 in FETCH, 3 in MEM); ready on the TIMEOUT-th cycle wins over timeout.
REQ-030 SHALL keep HALT and ERR absorbing until reset; all requests/enables 0 there; halt=1 only in HALT; err=1 only in ERR.
REQ-031 SHALL increment cycle_cnt every cycle in states 0..4, freeze in HALT/ERR, wrap 0xFFFFFFFF->0; instret_cnt wraps likewise.
REQ-032 SHALL drive if_req, inst_wen, mem_req, mem_wen, reg_wen, pc_wen combinationally from state, class register and ready inputs only (no path from inst_type to outputs).

Reset
REQ-033 SHALL, while rst=0, force state=FETCH, counters=0, err=0, err_code=0, halt=0, class register=0, wait counter=0 immediately (asynchronous).
REQ-034 SHALL assert if_req=1 in the first cycle after rst deasserts; reset mid-transaction abandons it with no pc_wen/reg_wen pulse.

Verification
REQ-035 addi (0x1), if_ready=1 at once -> states 0,1,2,4,0; reg_wen and pc_wen 1 in WB only; instret_cnt=1, cycle_cnt=4.
REQ-036 lw (0x20), mem_ready after 3 cycles -> mem_req high 3+1 cycles, mem_wen=0, then WB with reg_wen=1; instret_cnt=1.
REQ-037 sw (0x80), mem_ready=1 first MEM cycle -> mem_req=mem_wen=1, pc_wen=1 same cycle, reg_wen never 1, next state FETCH.
REQ-038 inst_type=0xFFFFFFFF -> ERR, err=1, err_code=1, cycle_cnt frozen; then ebreak (0x4) after reset -> HALT, halt=1, instret_cnt=1, pc_wen=0.
REQ-039 TIMEOUT=16, if_ready=0 for 16 cycles -> ERR, err_code=2; same with if_ready=1 on 16th cycle -> DECODE, no error.
REQ-040 rst pulsed low during MEM wait -> outputs cleared asynchronously, counters 0, FETCH with if_req=1 after release.
